// File: rtl/block_extreme_tracker_pkg.sv
// Shared types and constants for the block extreme tracker.
// The state encoding and mode constants are used by the top and the comparator.
package extreme_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/block_extreme_tracker_if.sv
// Sample-in / extreme-out bundle for block_extreme_tracker.
// The master side drives samples and control; the slave side is the tracker.
interface block_extreme_tracker_if #(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 16
) ();
  localparam int IDXW = $clog2(BLOCK_LEN);

  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             clear;
  logic [WIDTH-1:0] y;
  logic [IDXW-1:0]  y_idx;
  logic             y_valid;
  logic             blk_done;
  logic [WIDTH-1:0] blk_result;
  logic [IDXW-1:0]  blk_idx;

  modport master (
    output in_valid, data_in, mode, clear,
    input  y, y_idx, y_valid, blk_done, blk_result, blk_idx
  );

  modport slave (
    input  in_valid, data_in, mode, clear,
    output y, y_idx, y_valid, blk_done, blk_result, blk_idx
  );
endinterface

// File: rtl/block_extreme_tracker_cmp.sv
// Combinational "strictly better" compare for the extreme tracker.
// better=1 when b beats a: b>a in max mode, b<a in min mode; equality never wins.
module extreme_cmp
  import extreme_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             better
);

  logic w_gt;
  logic w_lt;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    if (SIGNED != 0) begin
      w_gt = $signed(b) > $signed(a);
      w_lt = $signed(b) < $signed(a);
    end else begin
      w_gt = b > a;
      w_lt = b < a;
    end
  end

  assign better = (mode == MODE_MIN) ? w_lt : w_gt;

endmodule

// File: rtl/block_extreme_tracker.sv
// Running max/min tracker over fixed-length sample blocks.
// Publishes the block extreme and its index every BLOCK_LEN accepted samples.
module block_extreme_tracker
  import extreme_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 16,
  parameter int SIGNED    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  block_extreme_tracker_if.slave bus
);

  localparam int              IDXW     = $clog2(BLOCK_LEN);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_LEN - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_cnt;
  logic             r_mode;
  logic [WIDTH-1:0] r_y;
  logic [IDXW-1:0]  r_y_idx;
  logic             r_y_valid;
  logic             r_blk_done;
  logic [WIDTH-1:0] r_blk_result;
  logic [IDXW-1:0]  r_blk_idx;

  logic             w_better;
  logic [WIDTH-1:0] w_next_y;
  logic [IDXW-1:0]  w_next_idx;

  extreme_cmp #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp (
    .a     (r_y),
    .b     (bus.data_in),
    .mode  (r_mode),
    .better(w_better)
  );

  // r_cnt is the 0-based index the incoming sample will take within the block.
  always_comb begin
    w_next_y   = r_y;
    w_next_idx = r_y_idx;
    if (w_better) begin
      w_next_y   = bus.data_in;
      w_next_idx = r_cnt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_cnt        <= '0;
      r_mode       <= MODE_MAX;
      r_y          <= '0;
      r_y_idx      <= '0;
      r_y_valid    <= 1'b0;
      r_blk_done   <= 1'b0;
      r_blk_result <= '0;
      r_blk_idx    <= '0;
    end else begin
      r_blk_done <= 1'b0;
      if (bus.clear) begin
        r_state   <= EMPTY;
        r_cnt     <= '0;
        r_y_valid <= 1'b0;
        r_y       <= '0;
        r_y_idx   <= '0;
      end else if (bus.in_valid) begin
        unique case (r_state)
          EMPTY: begin
            r_mode    <= bus.mode;
            r_y       <= bus.data_in;
            r_y_idx   <= '0;
            r_cnt     <= IDXW'(1);
            r_y_valid <= 1'b1;
            r_state   <= TRACK;
          end
          TRACK: begin
            r_y     <= w_next_y;
            r_y_idx <= w_next_idx;
            if (r_cnt == LAST_IDX) begin
              r_blk_result <= w_next_y;
              r_blk_idx    <= w_next_idx;
              r_blk_done   <= 1'b1;
              r_state      <= EMPTY;
              r_cnt        <= '0;
              r_y_valid    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.y          = r_y;
  assign bus.y_idx      = r_y_idx;
  assign bus.y_valid    = r_y_valid;
  assign bus.blk_done   = r_blk_done;
  assign bus.blk_result = r_blk_result;
  assign bus.blk_idx    = r_blk_idx;

endmodule

// File: tb/tb_block_extreme_tracker.sv
// Self-checking bench for block_extreme_tracker: directed scenarios on three
// parameterisations plus a randomized run against a queue-based block model.
module tb_block_extreme_tracker;
  import extreme_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  block_extreme_tracker_if #(.WIDTH(2), .BLOCK_LEN(16)) ifa ();
  block_extreme_tracker_if #(.WIDTH(8), .BLOCK_LEN(4))  ifb ();
  block_extreme_tracker_if #(.WIDTH(4), .BLOCK_LEN(4))  ifc ();

  block_extreme_tracker #(.WIDTH(2), .BLOCK_LEN(16), .SIGNED(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  block_extreme_tracker #(.WIDTH(8), .BLOCK_LEN(4),  .SIGNED(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  block_extreme_tracker #(.WIDTH(4), .BLOCK_LEN(4),  .SIGNED(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.in_valid = 1'b0; ifa.data_in = '0; ifa.mode = MODE_MAX; ifa.clear = 1'b0;
    ifb.in_valid = 1'b0; ifb.data_in = '0; ifb.mode = MODE_MAX; ifb.clear = 1'b0;
    ifc.in_valid = 1'b0; ifc.data_in = '0; ifc.mode = MODE_MAX; ifc.clear = 1'b0;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic m, input logic c);
    ifb.in_valid = v; ifb.data_in = d; ifb.mode = m; ifb.clear = c;
  endtask

  task automatic drive_c(input logic v, input logic [3:0] d, input logic m, input logic c);
    ifc.in_valid = v; ifc.data_in = d; ifc.mode = m; ifc.clear = c;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    #3;
    n_checks++;
    if ({ifa.y, ifa.y_idx, ifa.y_valid, ifa.blk_done, ifa.blk_result, ifa.blk_idx} !== '0)
      $display("FAIL reset_a: outputs=%h want 0", {ifa.y, ifa.y_idx, ifa.y_valid, ifa.blk_done, ifa.blk_result, ifa.blk_idx});
    else n_pass++;
    n_checks++;
    if ({ifb.y, ifb.y_idx, ifb.y_valid, ifb.blk_done, ifb.blk_result, ifb.blk_idx} !== '0)
      $display("FAIL reset_b: outputs=%h want 0", {ifb.y, ifb.y_idx, ifb.y_valid, ifb.blk_done, ifb.blk_result, ifb.blk_idx});
    else n_pass++;
    n_checks++;
    if ({ifc.y, ifc.y_idx, ifc.y_valid, ifc.blk_done, ifc.blk_result, ifc.blk_idx} !== '0)
      $display("FAIL reset_c: outputs=%h want 0", {ifc.y, ifc.y_idx, ifc.y_valid, ifc.blk_done, ifc.blk_result, ifc.blk_idx});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream_max();
    int s  [7] = '{0, 0, 1, 0, 2, 1, 3};
    int ey [7] = '{0, 0, 1, 1, 2, 2, 3};
    int ei [7] = '{0, 0, 2, 2, 4, 4, 6};
    for (int i = 0; i < 7; i++) begin
      ifa.in_valid = 1'b1; ifa.data_in = 2'(s[i]); ifa.mode = MODE_MAX;
      tick();
      n_checks++;
      if (ifa.y !== 2'(ey[i]) || ifa.y_idx !== 4'(ei[i]) || ifa.y_valid !== 1'b1)
        $display("FAIL stream_max[%0d]: y=%0d idx=%0d v=%b want y=%0d idx=%0d v=1",
                 i, ifa.y, ifa.y_idx, ifa.y_valid, ey[i], ei[i]);
      else n_pass++;
    end
    ifa.in_valid = 1'b0; ifa.clear = 1'b1;
    tick();
    ifa.clear = 1'b0;
  endtask

  task automatic test_min_tie();
    int s [4] = '{50, 20, 20, 90};
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'(s[i]), MODE_MIN, 1'b0);
      tick();
      if (ifb.blk_done === 1'b1) pulses++;
    end
    n_checks++;
    if (ifb.blk_done !== 1'b1 || ifb.blk_result !== 8'd20 || ifb.blk_idx !== 2'd1 || ifb.y_valid !== 1'b0)
      $display("FAIL min_tie_result: done=%b res=%0d idx=%0d yv=%b want 1/20/1/0",
               ifb.blk_done, ifb.blk_result, ifb.blk_idx, ifb.y_valid);
    else n_pass++;
    drive_b(1'b0, 8'd0, MODE_MIN, 1'b0);
    tick();
    if (ifb.blk_done === 1'b1) pulses++;
    tick();
    n_checks++;
    if (pulses != 1 || ifb.blk_result !== 8'd20 || ifb.blk_idx !== 2'd1)
      $display("FAIL min_tie_pulses: pulses=%0d res=%0d idx=%0d want 1/20/1", pulses, ifb.blk_result, ifb.blk_idx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s [8] = '{1, 9, 3, 4, 7, 2, 8, 8};
    int res[$];
    int idx[$];
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b1, 8'(s[i]), MODE_MAX, 1'b0);
      tick();
      if (ifb.blk_done === 1'b1) begin
        res.push_back(int'(ifb.blk_result));
        idx.push_back(int'(ifb.blk_idx));
      end
      if (i == 4) begin
        n_checks++;
        if (ifb.y !== 8'd7 || ifb.y_idx !== 2'd0 || ifb.y_valid !== 1'b1)
          $display("FAIL b2b_first: y=%0d idx=%0d v=%b want 7/0/1", ifb.y, ifb.y_idx, ifb.y_valid);
        else n_pass++;
      end
    end
    drive_b(1'b0, 8'd0, MODE_MAX, 1'b0);
    tick();
    if (ifb.blk_done === 1'b1) begin
      res.push_back(int'(ifb.blk_result));
      idx.push_back(int'(ifb.blk_idx));
    end
    n_checks++;
    if (res.size() != 2)
      $display("FAIL b2b_pulses: count=%0d want 2", res.size());
    else begin
      n_pass++;
      n_checks++;
      if (res[0] != 9 || idx[0] != 1 || res[1] != 8 || idx[1] != 2)
        $display("FAIL b2b_results: %0d/%0d %0d/%0d want 9/1 8/2", res[0], idx[0], res[1], idx[1]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_toggle();
    int s1 [4] = '{5, 3, 10, 1};
    int s2 [4] = '{6, 2, 9, 2};
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'(s1[i]), (i < 2) ? MODE_MAX : MODE_MIN, 1'b0);
      tick();
    end
    n_checks++;
    if (ifb.blk_done !== 1'b1 || ifb.blk_result !== 8'd10 || ifb.blk_idx !== 2'd2)
      $display("FAIL toggle_ignored: done=%b res=%0d idx=%0d want 1/10/2", ifb.blk_done, ifb.blk_result, ifb.blk_idx);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'(s2[i]), MODE_MIN, 1'b0);
      tick();
    end
    n_checks++;
    if (ifb.blk_done !== 1'b1 || ifb.blk_result !== 8'd2 || ifb.blk_idx !== 2'd1)
      $display("FAIL toggle_next_min: done=%b res=%0d idx=%0d want 1/2/1", ifb.blk_done, ifb.blk_result, ifb.blk_idx);
    else n_pass++;
    drive_b(1'b0, 8'd0, MODE_MAX, 1'b0);
    tick();
  endtask

  task automatic test_clear();
    int s [4] = '{3, 1, 5, 2};
    drive_b(1'b1, 8'd4, MODE_MAX, 1'b0); tick();
    drive_b(1'b1, 8'd7, MODE_MAX, 1'b0); tick();
    drive_b(1'b1, 8'd100, MODE_MAX, 1'b1); tick();
    n_checks++;
    if (ifb.y_valid !== 1'b0 || ifb.y !== 8'd0 || ifb.y_idx !== 2'd0 || ifb.blk_done !== 1'b0)
      $display("FAIL clear_state: yv=%b y=%0d idx=%0d done=%b want 0/0/0/0", ifb.y_valid, ifb.y, ifb.y_idx, ifb.blk_done);
    else n_pass++;
    n_checks++;
    if (ifb.blk_result !== 8'd2 || ifb.blk_idx !== 2'd1)
      $display("FAIL clear_blk_hold: res=%0d idx=%0d want 2/1", ifb.blk_result, ifb.blk_idx);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'(s[i]), MODE_MAX, 1'b0);
      tick();
      if (i == 0) begin
        n_checks++;
        if (ifb.y !== 8'd3 || ifb.y_idx !== 2'd0 || ifb.y_valid !== 1'b1)
          $display("FAIL clear_restart: y=%0d idx=%0d v=%b want 3/0/1", ifb.y, ifb.y_idx, ifb.y_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if (ifb.blk_done !== 1'b1 || ifb.blk_result !== 8'd5 || ifb.blk_idx !== 2'd2)
      $display("FAIL clear_block: done=%b res=%0d idx=%0d want 1/5/2", ifb.blk_done, ifb.blk_result, ifb.blk_idx);
    else n_pass++;
    drive_b(1'b0, 8'd0, MODE_MAX, 1'b0);
    tick();
  endtask

  task automatic test_signed_and_async_reset();
    drive_c(1'b1, 4'hF, MODE_MAX, 1'b0); tick();
    drive_c(1'b1, 4'h3, MODE_MAX, 1'b0); tick();
    drive_c(1'b1, 4'h8, MODE_MAX, 1'b0); tick();
    n_checks++;
    if (ifc.y !== 4'h3 || ifc.y_idx !== 2'd1 || ifc.y_valid !== 1'b1)
      $display("FAIL signed_max: y=%h idx=%0d v=%b want 3/1/1", ifc.y, ifc.y_idx, ifc.y_valid);
    else n_pass++;
    drive_c(1'b0, 4'h0, MODE_MAX, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({ifc.y, ifc.y_idx, ifc.y_valid, ifc.blk_done, ifc.blk_result, ifc.blk_idx} !== '0)
      $display("FAIL async_reset: outputs=%h want 0", {ifc.y, ifc.y_idx, ifc.y_valid, ifc.blk_done, ifc.blk_result, ifc.blk_idx});
    else n_pass++;
    rst = 1'b0;
    drive_c(1'b1, 4'h8, MODE_MAX, 1'b0); tick();
    drive_c(1'b1, 4'hF, MODE_MAX, 1'b0); tick();
    n_checks++;
    if (ifc.y !== 4'hF || ifc.y_idx !== 2'd1 || ifc.y_valid !== 1'b1)
      $display("FAIL signed_after_reset: y=%h idx=%0d v=%b want F/1/1", ifc.y, ifc.y_idx, ifc.y_valid);
    else n_pass++;
    drive_c(1'b0, 4'h0, MODE_MAX, 1'b1); tick();
    drive_c(1'b0, 4'h0, MODE_MAX, 1'b0);
  endtask

  function automatic int to_val(input int raw, input int w, input bit sg);
    if (sg && raw >= (1 << (w - 1))) return raw - (1 << w);
    return raw;
  endfunction

  // Block extreme by value first, then the earliest position holding that value.
  function automatic void extreme_of(input int q[$], input int mn, output int val, output int idx);
    val = q[0];
    foreach (q[i]) if ((mn != 0) ? (q[i] < val) : (q[i] > val)) val = q[i];
    idx = 0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i] == val) idx = i;
  endfunction

  task automatic get_out(input int sel, output logic [31:0] oy, output logic [31:0] oi,
                         output logic [31:0] ov, output logic [31:0] od,
                         output logic [31:0] obr, output logic [31:0] obi);
    if (sel == 0) begin
      oy = 32'(ifb.y); oi = 32'(ifb.y_idx); ov = 32'(ifb.y_valid);
      od = 32'(ifb.blk_done); obr = 32'(ifb.blk_result); obi = 32'(ifb.blk_idx);
    end else begin
      oy = 32'(ifc.y); oi = 32'(ifc.y_idx); ov = 32'(ifc.y_valid);
      od = 32'(ifc.blk_done); obr = 32'(ifc.blk_result); obi = 32'(ifc.blk_idx);
    end
  endtask

  task automatic test_random(input int sel, input int cycles);
    int w    = (sel == 0) ? 8 : 4;
    bit sg   = (sel != 0);
    int mask = (1 << w) - 1;
    int q[$];
    int mmode = 0, exp_br = 0, exp_bi = 0, exp_y = 0, exp_yi = 0, exp_yv = 0, exp_done = 0;
    bit y_known = 1'b1;
    int ev, ei;
    logic [31:0] oy, oi, ov, od, obr, obi;
    idle_all();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    for (int n = 0; n < cycles; n++) begin
      logic v, c, m;
      int d;
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(19) == 0);
      m = 1'($urandom_range(1));
      d = int'($urandom_range(mask));
      if (sel == 0) drive_b(v, 8'(d), m, c);
      else          drive_c(v, 4'(d), m, c);
      exp_done = 0;
      if (c) begin
        q.delete();
        y_known = 1'b1; exp_y = 0; exp_yi = 0; exp_yv = 0;
      end else if (v) begin
        if (q.size() == 0) mmode = int'(m);
        q.push_back(to_val(d, w, sg));
        extreme_of(q, mmode, ev, ei);
        if (q.size() == 4) begin
          exp_br = ev & mask; exp_bi = ei; exp_done = 1;
          q.delete();
          y_known = 1'b0; exp_yv = 0;
        end else begin
          y_known = 1'b1; exp_y = ev & mask; exp_yi = ei; exp_yv = 1;
        end
      end
      tick();
      get_out(sel, oy, oi, ov, od, obr, obi);
      n_checks++;
      if (od !== 32'(exp_done) || obr !== 32'(exp_br) || obi !== 32'(exp_bi))
        $display("FAIL rand%0d_blk[%0d]: done=%0d res=%0d idx=%0d want %0d/%0d/%0d",
                 sel, n, od, obr, obi, exp_done, exp_br, exp_bi);
      else n_pass++;
      n_checks++;
      if (ov !== 32'(exp_yv))
        $display("FAIL rand%0d_yvalid[%0d]: v=%0d want %0d", sel, n, ov, exp_yv);
      else n_pass++;
      if (y_known) begin
        n_checks++;
        if (oy !== 32'(exp_y) || oi !== 32'(exp_yi))
          $display("FAIL rand%0d_y[%0d]: y=%0d idx=%0d want %0d/%0d", sel, n, oy, oi, exp_y, exp_yi);
        else n_pass++;
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_stream_max();
    test_min_tie();
    test_back_to_back();
    test_mode_toggle();
    test_clear();
    test_signed_and_async_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
